// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller:
// FSM state encoding, coin values, credit ceiling and slot price table.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_FAULT    = 3'd4
    } vend_state_e;

    localparam logic [11:0] COIN_QUARTER = 12'd25;
    localparam logic [11:0] COIN_DOLLAR  = 12'd100;
    localparam logic [11:0] CREDIT_SAT   = 12'd4095;

    // Price in cents of each product slot.
    function automatic logic [11:0] slot_price(input logic [1:0] slot);
        logic [11:0] price;
        case (slot)
            2'd0:    price = 12'd25;
            2'd1:    price = 12'd50;
            2'd2:    price = 12'd75;
            2'd3:    price = 12'd100;
            default: price = 12'd100;
        endcase
        return price;
    endfunction

endpackage

// File: rtl/vend_txn_ctrl_if.sv
// Front-panel / actuator bundle of the vending transaction controller.
// master = panel and actuator side, slave = the controller.
interface vend_txn_ctrl_if #(
    parameter int NUM_SLOTS = 4,
    parameter int CREDIT_W  = 12
);
    logic                 quater;
    logic                 dollar;
    logic [NUM_SLOTS-1:0] select;
    logic                 buy;
    logic                 cancel;
    logic [NUM_SLOTS-1:0] load;
    logic                 motor_done;
    logic [NUM_SLOTS-1:0] motor_en;
    logic                 change_pulse;
    logic [CREDIT_W-1:0]  money;
    logic                 vend_ok;
    logic                 vend_fail;
    logic [NUM_SLOTS-1:0] out_of_stock;
    logic                 busy;
    logic                 fault;

    modport master (
        output quater, dollar, select, buy, cancel, load, motor_done,
        input  motor_en, change_pulse, money, vend_ok, vend_fail,
               out_of_stock, busy, fault
    );

    modport slave (
        input  quater, dollar, select, buy, cancel, load, motor_done,
        output motor_en, change_pulse, money, vend_ok, vend_fail,
               out_of_stock, busy, fault
    );
endinterface

// File: rtl/vend_edge_det.sv
// Single-bit rising-edge detector. The edge is flagged combinationally in
// the first cycle the level is seen high so the controller acts on it at
// the very next clock edge.
module vend_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);
    logic prev_r;

    // Remember the previous sampled level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= level;
        end
    end

    assign rise = level & ~prev_r;
endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: credits coins, checks a selection
// against stock and price, drives the dispense motor with a timeout,
// and returns change as quarter pulses.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int NUM_SLOTS     = 4,
    parameter int CREDIT_W      = 12,
    parameter int STOCK_MAX     = 15,
    parameter int MOTOR_TIMEOUT = 255
) (
    input logic           clk,
    input logic           reset,
    vend_txn_ctrl_if.slave bus
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int SUM_W  = CREDIT_W + 2;
    localparam int CNT_W  = $clog2(MOTOR_TIMEOUT + 1);

    vend_state_e          state_r;
    logic [SLOT_W-1:0]    slot_r;
    logic [CREDIT_W-1:0]  money_r;
    logic [3:0]           stock_r [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] motor_en_r;
    logic [NUM_SLOTS-1:0] oos_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 phase_r;
    logic                 vend_ok_r;
    logic                 vend_fail_r;
    logic                 change_pulse_r;
    logic                 busy_r;
    logic                 fault_r;

    logic                 quater_rise_s;
    logic                 dollar_rise_s;
    logic                 buy_rise_s;
    logic                 cancel_rise_s;
    logic [SLOT_W-1:0]    sel_idx_s;
    logic [CREDIT_W-1:0]  price_s;
    logic                 check_pass_s;
    logic                 timeout_s;
    logic [SUM_W-1:0]     add_s;
    logic [SUM_W-1:0]     inc_s;
    logic [SUM_W-1:0]     dec_s;
    logic [SUM_W-1:0]     sum_s;
    logic [CREDIT_W-1:0]  money_nxt_s;
    logic [3:0]           stock_nxt_s [NUM_SLOTS];

    vend_edge_det u_edge_quater (.clk(clk), .reset(reset), .level(bus.quater), .rise(quater_rise_s));
    vend_edge_det u_edge_dollar (.clk(clk), .reset(reset), .level(bus.dollar), .rise(dollar_rise_s));
    vend_edge_det u_edge_buy    (.clk(clk), .reset(reset), .level(bus.buy),    .rise(buy_rise_s));
    vend_edge_det u_edge_cancel (.clk(clk), .reset(reset), .level(bus.cancel), .rise(cancel_rise_s));

    // Selection index, price of the latched slot and the CHECK / timeout decisions.
    always_comb begin
        sel_idx_s = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            sel_idx_s = bus.select[i] ? SLOT_W'(i) : sel_idx_s;
        end
        price_s      = CREDIT_W'(slot_price(2'(slot_r)));
        check_pass_s = (state_r == ST_CHECK) && (stock_r[slot_r] != 4'd0) &&
                       (money_r >= price_s);
        timeout_s    = (state_r == ST_DISPENSE) && !bus.motor_done &&
                       (cnt_r == CNT_W'(MOTOR_TIMEOUT - 1));
    end

    // Net credit update: coins plus refund minus purchase or returned quarter,
    // saturating at the credit ceiling. A saturated, non-multiple-of-25 credit
    // returns its remainder on the last change pulse.
    always_comb begin
        add_s = '0;
        if (state_r != ST_FAULT) begin
            add_s = (quater_rise_s ? SUM_W'(COIN_QUARTER) : SUM_W'(0)) +
                    (dollar_rise_s ? SUM_W'(COIN_DOLLAR)  : SUM_W'(0));
        end else begin
            add_s = '0;
        end
        inc_s = timeout_s ? SUM_W'(price_s) : SUM_W'(0);
        if (check_pass_s) begin
            dec_s = SUM_W'(price_s);
        end else if ((state_r == ST_CHANGE) && !phase_r && (money_r != '0)) begin
            dec_s = (money_r < CREDIT_W'(COIN_QUARTER)) ? SUM_W'(money_r) : SUM_W'(COIN_QUARTER);
        end else begin
            dec_s = '0;
        end
        sum_s = SUM_W'(money_r) + add_s + inc_s - dec_s;
        if (sum_s > SUM_W'(CREDIT_SAT)) begin
            money_nxt_s = CREDIT_W'(CREDIT_SAT);
        end else begin
            money_nxt_s = CREDIT_W'(sum_s);
        end
    end

    // Next stock per slot: restock overrides the purchase decrement.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.load[i]) begin
                stock_nxt_s[i] = 4'(STOCK_MAX);
            end else if (check_pass_s && (slot_r == SLOT_W'(i))) begin
                stock_nxt_s[i] = stock_r[i] - 4'd1;
            end else begin
                stock_nxt_s[i] = stock_r[i];
            end
        end
    end

    // Transaction FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            slot_r         <= '0;
            money_r        <= '0;
            motor_en_r     <= '0;
            oos_r          <= '0;
            cnt_r          <= '0;
            phase_r        <= 1'b0;
            vend_ok_r      <= 1'b0;
            vend_fail_r    <= 1'b0;
            change_pulse_r <= 1'b0;
            busy_r         <= 1'b0;
            fault_r        <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                stock_r[i] <= 4'(STOCK_MAX);
            end
        end else begin
            money_r        <= money_nxt_s;
            vend_ok_r      <= 1'b0;
            vend_fail_r    <= 1'b0;
            change_pulse_r <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                stock_r[i] <= stock_nxt_s[i];
                oos_r[i]   <= (stock_r[i] == 4'd0);
            end
            case (state_r)
                ST_IDLE: begin
                    if (buy_rise_s) begin
                        if ($onehot(bus.select)) begin
                            slot_r  <= sel_idx_s;
                            state_r <= ST_CHECK;
                            busy_r  <= 1'b1;
                        end else begin
                            vend_fail_r <= 1'b1;
                        end
                    end else if (cancel_rise_s && (money_r != '0)) begin
                        phase_r <= 1'b0;
                        state_r <= ST_CHANGE;
                        busy_r  <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (check_pass_s) begin
                        motor_en_r <= NUM_SLOTS'(1) << slot_r;
                        cnt_r      <= '0;
                        state_r    <= ST_DISPENSE;
                    end else begin
                        vend_fail_r <= 1'b1;
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                    end
                end
                ST_DISPENSE: begin
                    if (bus.motor_done) begin
                        motor_en_r <= '0;
                        vend_ok_r  <= 1'b1;
                        phase_r    <= 1'b0;
                        if (money_nxt_s != '0) begin
                            state_r <= ST_CHANGE;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else if (timeout_s) begin
                        motor_en_r <= '0;
                        fault_r    <= 1'b1;
                        phase_r    <= 1'b0;
                        state_r    <= ST_CHANGE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_CHANGE: begin
                    if (phase_r) begin
                        phase_r <= 1'b0;
                    end else if (money_r != '0) begin
                        change_pulse_r <= 1'b1;
                        phase_r        <= 1'b1;
                    end else begin
                        state_r <= fault_r ? ST_FAULT : ST_IDLE;
                        busy_r  <= fault_r;
                    end
                end
                ST_FAULT: begin
                    if (buy_rise_s) begin
                        vend_fail_r <= 1'b1;
                    end
                end
                default: begin
                    motor_en_r <= '0;
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.motor_en     = motor_en_r;
    assign bus.change_pulse = change_pulse_r;
    assign bus.money        = money_r;
    assign bus.vend_ok      = vend_ok_r;
    assign bus.vend_fail    = vend_fail_r;
    assign bus.out_of_stock = oos_r;
    assign bus.busy         = busy_r;
    assign bus.fault        = fault_r;
endmodule

// File: doc/vend_txn_ctrl.md
Name: vend_txn_ctrl

Overview:
Transaction controller for the 4-slot vending machine. It sequences each purchase: coin crediting, selection check, the dispense motor handshake with timeout, and change return as quarter pulses. It owns the credit register and the per-slot stock counters, and sits between the front-panel inputs and the motor/coin-return actuators.

Parameters:
NUM_SLOTS, 4, number of product slots; select/load/motor_en/out_of_stock width.
CREDIT_W, 12, credit register width in cents.
STOCK_MAX, 15, stock value written by load; stock counters are 4 bits.
MOTOR_TIMEOUT, 255, cycles in DISPENSE without motor_done before a fault is declared.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
quater  in  1  quarter-accepted level; rising edge credits 25.
dollar  in  1  dollar-accepted level; rising edge credits 100.
select  in  NUM_SLOTS  one-hot slot selection, sampled on buy edge.
buy  in  1  purchase request level; rising edge starts a transaction.
cancel  in  1  refund request level; rising edge honoured in IDLE only.
load  in  NUM_SLOTS  one-hot restock; bit i high sets stock[i]=STOCK_MAX.
motor_done  in  1  dispense motor completion, level.
motor_en  out  NUM_SLOTS  one-hot motor drive for the slot being dispensed.
change_pulse  out  1  one-cycle pulse per quarter returned.
money  out  CREDIT_W  current credit in cents.
vend_ok  out  1  one-cycle pulse on successful dispense.
vend_fail  out  1  one-cycle pulse on rejected buy.
out_of_stock  out  NUM_SLOTS  bit i = (stock[i]==0).
busy  out  1  state != IDLE.
fault  out  1  sticky motor-timeout flag.

Behaviour:
- Reset (reset low, async): state=IDLE, money=0, stock[all]=STOCK_MAX, all pulses/motor_en/fault=0, edge-detect history=0. Reset mid-dispense drops motor_en immediately.
- Edge detection: registered previous value per input; an edge is cur=1 and prev=0. All actions act on the edge cycle.
- Crediting: accepted in every state except FAULT. quater and dollar edges in the same cycle credit 125. Sum saturates at 4095. Credit lands in the same cycle as a CHANGE decrement: net update applied.
- Prices, in cents: slot0=25, slot1=50, slot2=75, slot3=100.
- IDLE:
  - buy edge with select exactly one-hot: latch the slot, go to CHECK.
  - buy edge with select zero or multi-hot: vend_fail pulse, stay in IDLE.
  - cancel edge with money>0: go to CHANGE. With money=0: ignored.
  - buy and cancel edges together: buy wins.
- CHECK (1 cycle):
  - If stock==0 or money<price: vend_fail pulse, go to IDLE.
  - Else: money-=price, stock-=1, motor_en[slot]=1 from the next cycle, go to DISPENSE.
- DISPENSE:
  - Hold motor_en and count cycles.
  - motor_done=1: motor_en=0 next cycle, vend_ok pulse. Go to CHANGE if money>0, else IDLE.
  - Count reaches MOTOR_TIMEOUT: motor_en=0, money+=price (refund), fault=1, go to CHANGE.
- CHANGE:
  - Alternate change_pulse high one cycle, low one cycle. money-=25 on each high cycle.
  - When money reaches 0: go to FAULT if fault, else IDLE.
- FAULT:
  - buy edges give vend_fail. Coins are ignored. Only reset exits.
- load: honoured in any state. If it coincides with the CHECK decrement of the same slot, load wins (stock=STOCK_MAX).
- out_of_stock is registered from the stock counters and updates one cycle after a stock change.

Decomposition:
- Package vend_pkg holds:
  - the state enum (IDLE, CHECK, DISPENSE, CHANGE, FAULT);
  - the PRICE constants per slot;
  - the coin values 25 and 100;
  - the saturation limit.
- Sub-module vend_edge_det: a 1-bit rising-edge detector with async active-low reset, instantiated for quater, dollar, buy and cancel.

Test Plan:
- Two quater edges, then buy with select=0010 and motor_done 3 cycles after motor_en: money 50→0, motor_en=0010 for 3 cycles, one vend_ok, no change_pulse.
- dollar edge, then buy with select=0001 and motor_done: money 100→75 at CHECK, vend_ok, then 3 change_pulses, money=0, busy low.
- quater edge, then buy with select=1000: vend_fail pulse, money stays 25, no motor_en. Then cancel: 1 change_pulse, money=0.
- 15 successful slot0 vends: out_of_stock[0]=1 and the 16th buy gives vend_fail. Then load=0001: stock=15, out_of_stock[0]=0.
- dollar, buy slot3 with motor_done held low: motor_en drops after 255 cycles, money refunded to 100, 4 change_pulses, fault=1. A later buy gives vend_fail; reset clears fault.
- Assert reset during DISPENSE: motor_en, money and busy go to 0 asynchronously, and stock returns to 15.
